// File: rtl/time_field_blink_disp_if.sv
// Bus bundle for the time-field display controller: field values and blink
// select towards the controller, segment patterns and busy flag back out.
interface time_field_blink_disp_if #(
  parameter int FIELDS = 3,
  parameter int VAL_W  = 7,
  parameter int SEL_W  = 2
);
  logic [FIELDS*VAL_W-1:0] values;
  logic [SEL_W-1:0]        sel;
  logic [FIELDS*14-1:0]    seg;
  logic                    busy;

  modport master (output values, output sel, input seg, input busy);
  modport slave  (input values, input sel, output seg, output busy);
endinterface

// File: rtl/time_field_blink_disp.sv
// Time-field seven-segment controller: sequential binary-to-BCD conversion with an
// atomic commit, plus field blinking. Optional macro: TIME_FIELD_LEAD_ZERO_BLANK_EN.
module time_field_blink_disp #(
  parameter int FIELDS    = 3,
  parameter int VAL_W     = 7,
  parameter int SEL_W     = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   resetn,
  time_field_blink_disp_if.slave bus
);
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam int FI_W  = (FIELDS > 1) ? $clog2(FIELDS) : 1;
`ifdef TIME_FIELD_LEAD_ZERO_BLANK_EN
  localparam logic [FIELDS*14-1:0] SEG_RST = {7'h00, {(FIELDS*2-1){7'h3F}}};
`else
  localparam logic [FIELDS*14-1:0] SEG_RST = {(FIELDS*2){7'h3F}};
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                  state;
  logic [FIELDS*VAL_W-1:0] snap;
  logic [FIELDS-1:0]       oor;
  logic [FI_W-1:0]         f;
  logic [3:0]              step;
  logic [VAL_W-1:0]        rem, rem_nx, next_val;
  logic [3:0]              tens, tens_nx;
  logic [3:0]              stg_tens [FIELDS];
  logic [3:0]              stg_ones [FIELDS];
  logic [FIELDS-1:0]       stg_dash;
  logic [3:0]              disp_tens [FIELDS];
  logic [3:0]              disp_ones [FIELDS];
  logic [FIELDS-1:0]       disp_dash;
  logic                    busy_r;
  logic [CNT_W-1:0]        cnt;
  logic                    phase;
  logic [SEL_W-1:0]        sel_q;
  logic [FIELDS*14-1:0]    seg_nx, seg_r;
  logic [6:0]              t_code, o_code;

  // One restoring-subtract step of the decimal split.
  always_comb begin
    rem_nx  = rem;
    tens_nx = tens;
    if (int'(rem) >= 10) begin
      rem_nx  = rem - VAL_W'(10);
      tens_nx = tens + 4'd1;
    end
    next_val = '0;
    for (int i = 0; i < FIELDS; i++)
      if (int'(f) + 1 == i) next_val = snap[i*VAL_W +: VAL_W];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      snap      <= '0;
      oor       <= '0;
      f         <= '0;
      step      <= '0;
      rem       <= '0;
      tens      <= '0;
      busy_r    <= 1'b0;
      stg_dash  <= '0;
      disp_dash <= '0;
      for (int i = 0; i < FIELDS; i++) begin
        stg_tens[i]  <= '0;
        stg_ones[i]  <= '0;
        disp_tens[i] <= '0;
        disp_ones[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.values != snap) begin
            snap   <= bus.values;
            f      <= '0;
            step   <= '0;
            tens   <= '0;
            rem    <= bus.values[VAL_W-1:0];
            busy_r <= 1'b1;
            state  <= CONV;
            for (int i = 0; i < FIELDS; i++)
              oor[i] <= (int'(bus.values[i*VAL_W +: VAL_W]) > 99);
          end
        end
        CONV: begin
          if (step == 4'd9) begin
            for (int i = 0; i < FIELDS; i++) begin
              if (f == FI_W'(i)) begin
                stg_tens[i] <= tens_nx;
                stg_ones[i] <= rem_nx[3:0];
                stg_dash[i] <= oor[i];
              end
            end
            step <= '0;
            tens <= '0;
            rem  <= next_val;
            f    <= f + FI_W'(1);
            if (f == FI_W'(FIELDS-1)) state <= COMMIT;
          end else begin
            step <= step + 4'd1;
            rem  <= rem_nx;
            tens <= tens_nx;
          end
        end
        COMMIT: begin
          disp_tens <= stg_tens;
          disp_ones <= stg_ones;
          disp_dash <= stg_dash;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A sel change restarts the half-period so the new field shows at once.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt   <= '0;
      phase <= 1'b1;
      sel_q <= '0;
    end else if (bus.sel != sel_q) begin
      sel_q <= bus.sel;
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_W'(BLINK_DIV-1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    seg_nx = '0;
    t_code = '0;
    o_code = '0;
    for (int i = 0; i < FIELDS; i++) begin
      t_code = disp_dash[i] ? 7'h40 : seg7(disp_tens[i]);
      o_code = disp_dash[i] ? 7'h40 : seg7(disp_ones[i]);
`ifdef TIME_FIELD_LEAD_ZERO_BLANK_EN
      if (i == FIELDS-1 && !disp_dash[i] && disp_tens[i] == 4'd0) t_code = 7'h00;
`endif
      if (!phase && int'(sel_q) == i + 1) begin
        t_code = 7'h00;
        o_code = 7'h00;
      end
      seg_nx[14*i +: 7]   = o_code;
      seg_nx[14*i+7 +: 7] = t_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) seg_r <= SEG_RST;
    else         seg_r <= seg_nx;
  end

  assign bus.seg  = seg_r;
  assign bus.busy = busy_r;
endmodule
